// File: rtl/processor_fetch_pkg.sv
// Shared constants and types for the sequential instruction-fetch prefetcher.
package processor_fetch_pkg;

  localparam int unsigned DEF_ADDR_W = 11;
  localparam int unsigned DEF_DATA_W = 32;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t StIdle  = 1'b0;
  localparam fetch_state_t StFetch = 1'b1;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } fetch_entry_t;

  // Occupancy counters must be able to represent a completely full FIFO.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/processor_fetch_prefetch_if.sv
// Consumer stream and RAM port bundle for the prefetcher; master is the prefetcher side.
interface processor_fetch_prefetch_if #(
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned DATA_W = 32
);

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_addr;

  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    input  out_ready,
    output mem_address,
    output mem_chipselect,
    output mem_write,
    output mem_byteenable,
    output mem_clken,
    input  mem_readdata
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    output out_ready,
    input  mem_address,
    input  mem_chipselect,
    input  mem_write,
    input  mem_byteenable,
    input  mem_clken,
    output mem_readdata
  );

endinterface

// File: rtl/processor_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; occupancy is exported for credit accounting.
module processor_fetch_fifo
  import processor_fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_ADDR_W + DEF_DATA_W,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = cnt_width(DEPTH),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;

  // DEPTH need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_data;
  end

  push_into_full_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && full && !flush));
  pop_from_empty_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(pop && empty && !flush));

endmodule

// File: rtl/processor_fetch_prefetch.sv
// Sequential instruction prefetcher: streams words from a single-port RAM with one-cycle
// read latency into a small FIFO, restarting cleanly on each redirect.
module processor_fetch_prefetch
  import processor_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [ADDR_W-1:0]          start_addr,
  input  logic                       halt,
  output logic                       busy,
  processor_fetch_prefetch_if.master bus
);

  localparam int unsigned CNT_W = cnt_width(DEPTH);

  fetch_state_t              state_q, state_d;
  logic [ADDR_W-1:0]         fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0]         inflight_addr_q;
  logic                      inflight_q;
  logic                      issue;
  logic                      push;
  logic                      pop;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W:0]            credit_used;
  logic [ADDR_W+DATA_W-1:0]  fifo_rdata;

  // An outstanding read already owns a FIFO slot, so it counts against the credit.
  assign credit_used = {1'b0, fifo_count} + (CNT_W+1)'(inflight_q);
  assign issue       = (state_q == StFetch) && !start && !halt &&
                       (credit_used < (CNT_W+1)'(DEPTH));

  // A read returning in a redirect cycle belongs to the old stream and is dropped.
  assign push = inflight_q && !start;

  assign bus.out_valid = !fifo_empty && !start;
  assign pop           = bus.out_valid && bus.out_ready;
  assign {bus.out_addr, bus.out_data} = bus.out_valid ? fifo_rdata : '0;

  assign bus.mem_address    = fetch_ptr_q;
  assign bus.mem_chipselect = issue;
  assign bus.mem_write      = 1'b0;
  assign bus.mem_byteenable = 4'hF;
  assign bus.mem_clken      = 1'b1;

  assign busy = (state_q == StFetch);

  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    if (start) begin
      state_d     = StFetch;
      fetch_ptr_d = start_addr;
    end else begin
      if (halt)  state_d     = StIdle;
      if (issue) fetch_ptr_d = fetch_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= StIdle;
      fetch_ptr_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      inflight_q  <= issue;
      if (issue) inflight_addr_q <= fetch_ptr_q;
    end
  end

  processor_fetch_fifo #(
    .WIDTH (ADDR_W + DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (start),
    .push      (push),
    .push_data ({inflight_addr_q, bus.mem_readdata}),
    .pop       (pop),
    .pop_data  (fifo_rdata),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_processor_fetch_prefetch.sv
// Scoreboard bench for processor_fetch_prefetch with a behavioural one-cycle-latency RAM.
module tb_processor_fetch_prefetch;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic              halt = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic              busy;

  processor_fetch_prefetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  processor_fetch_prefetch #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .start_addr (start_addr),
    .halt       (halt),
    .busy       (busy),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  logic [DATA_W-1:0] ram [2**ADDR_W];

  always @(posedge clk) begin
    if (bus.mem_chipselect && bus.mem_clken && !bus.mem_write)
      bus.mem_readdata <= ram[bus.mem_address];
  end

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [ADDR_W-1:0] exp_q [$];
  int xfers = 0;
  int issues = 0;
  int cyc = 0;
  int xfer_at [int];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    if (reset_n && bus.mem_chipselect) issues++;
    if (reset_n && bus.out_valid && bus.out_ready) begin
      check_eq("sb_pending", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        ea = exp_q.pop_front();
        check_eq("out_addr", 32'(bus.out_addr), 32'(ea));
        check_eq("out_data", bus.out_data, ram[ea]);
      end
      xfer_at[xfers] = cyc;
      xfers++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(a + ADDR_W'(i));
    start_addr = a;
    start = 1'b1;
    @(negedge clk);
    check_eq("start_no_valid", 32'(bus.out_valid), 32'd0);
    check_eq("start_no_issue", 32'(bus.mem_chipselect), 32'd0);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_xfers(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (xfers < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(xfers), 32'(target));
  endtask

  int base;
  int base_iss;

  initial begin
    for (int i = 0; i < 2**ADDR_W; i++) ram[i] = 32'h5A00_0000 ^ (i * 32'h9E37_79B1);
    bus.out_ready = 1'b0;

    repeat (3) tick();
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_cs", 32'(bus.mem_chipselect), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_addr", 32'(bus.mem_address), 32'd0);
    check_eq("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check_eq("rst_write", 32'(bus.mem_write), 32'd0);
    check_eq("rst_be", 32'(bus.mem_byteenable), 32'hF);
    check_eq("rst_clken", 32'(bus.mem_clken), 32'd1);
    reset_n = 1'b1;
    tick();

    // Streaming from 0x010 with the consumer always ready.
    bus.out_ready = 1'b1;
    base = xfers;
    do_start(11'h010, 8);
    check_eq("busy_after_start", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("c1_valid", 32'(bus.out_valid), 32'd0);
    check_eq("c1_cs", 32'(bus.mem_chipselect), 32'd1);
    check_eq("c1_addr", 32'(bus.mem_address), 32'h010);
    tick();
    @(negedge clk);
    check_eq("c2_valid", 32'(bus.out_valid), 32'd0);
    tick();
    @(negedge clk);
    check_eq("c3_valid", 32'(bus.out_valid), 32'd1);
    check_eq("c3_addr", 32'(bus.out_addr), 32'h010);
    wait_xfers("seq_count", base + 8, 20);
    bus.out_ready = 1'b0;
    check_eq("seq_span", 32'(xfer_at[base + 7] - xfer_at[base]), 32'd7);

    // Backpressure: credit limits issues to DEPTH, then drain and resume.
    base_iss = issues;
    do_start(11'h300, 6);
    repeat (10) tick();
    check_eq("credit_issues", 32'(issues - base_iss), 32'(DEPTH));
    check_eq("credit_cs_idle", 32'(bus.mem_chipselect), 32'd0);
    base = xfers;
    bus.out_ready = 1'b1;
    wait_xfers("drain_count", base + 6, 20);
    bus.out_ready = 1'b0;

    // Address wrap at the top of the RAM.
    base = xfers;
    bus.out_ready = 1'b1;
    do_start(11'h7FE, 4);
    wait_xfers("wrap_count", base + 4, 20);
    bus.out_ready = 1'b0;

    // Redirect with a word buffered and a read outstanding.
    do_start(11'h100, 0);
    tick();
    tick();
    check_eq("redir_pre_valid", 32'(bus.out_valid), 32'd1);
    check_eq("redir_pre_cs", 32'(bus.mem_chipselect), 32'd1);
    bus.out_ready = 1'b1;
    base = xfers;
    do_start(11'h200, 4);
    wait_xfers("redir_count", base + 4, 20);
    bus.out_ready = 1'b0;
    check_eq("redir_span", 32'(xfer_at[base + 3] - xfer_at[base]), 32'd3);

    // Halt with one read in flight: it still lands, nothing further is issued.
    do_start(11'h050, 1);
    tick();
    halt = 1'b1;
    base_iss = issues;
    @(negedge clk);
    check_eq("halt_cs", 32'(bus.mem_chipselect), 32'd0);
    check_eq("halt_busy_same", 32'(busy), 32'd1);
    tick();
    halt = 1'b0;
    check_eq("halt_busy_next", 32'(busy), 32'd0);
    check_eq("halt_landed", 32'(bus.out_valid), 32'd1);
    check_eq("halt_landed_addr", 32'(bus.out_addr), 32'h050);
    repeat (4) tick();
    check_eq("halt_no_issue", 32'(issues - base_iss), 32'd0);
    base = xfers;
    bus.out_ready = 1'b1;
    wait_xfers("halt_drain", base + 1, 5);
    tick();
    tick();
    check_eq("halt_empty", 32'(bus.out_valid), 32'd0);
    check_eq("halt_one_word", 32'(xfers), 32'(base + 1));

    // start and halt together: start wins.
    halt = 1'b1;
    base = xfers;
    do_start(11'h060, 3);
    halt = 1'b0;
    check_eq("start_halt_busy", 32'(busy), 32'd1);
    wait_xfers("start_halt_count", base + 3, 20);
    bus.out_ready = 1'b0;

    // Asynchronous reset with a full FIFO.
    do_start(11'h400, 0);
    repeat (6) tick();
    check_eq("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("arst_cs", 32'(bus.mem_chipselect), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    exp_q.delete();
    bus.out_ready = 1'b1;
    base = xfers;
    tick();
    tick();
    reset_n = 1'b1;
    repeat (6) tick();
    check_eq("post_rst_no_words", 32'(xfers), 32'(base));
    check_eq("post_rst_valid", 32'(bus.out_valid), 32'd0);

    do_start(11'h020, 2);
    wait_xfers("post_rst_count", base + 2, 20);
    bus.out_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/processor_fetch_prefetch.md
# processor_fetch_prefetch

Sequential instruction-fetch prefetcher that sits directly upstream of the processor's 2048×32 single-port on-chip RAM. It issues back-to-back word reads from a start address, absorbs the RAM's one-cycle read latency, and presents fetched words with their addresses to the consumer through a valid/ready stream buffered in a small FIFO. On a redirect it discards all buffered and in-flight data and restarts at the new address.

## Interface
- ADDR_W, 11, word-address width; matches the RAM depth of 2048 words
- DATA_W, 32, word width
- DEPTH, 4, FIFO entries; legal range 2..16
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  redirect pulse: flush and begin fetching at start_addr
- start_addr  in  ADDR_W  word address for redirect
- halt  in  1  stop issuing new reads
- busy  out  1  high in FETCH state
- out_valid  out  1  out_data/out_addr hold a fetched word
- out_ready  in  1  consumer accepts the word
- out_data  out  DATA_W  fetched word
- out_addr  out  ADDR_W  word address of out_data
- mem_address  out  ADDR_W  RAM address
- mem_chipselect  out  1  read issue strobe
- mem_write  out  1  constant 0
- mem_byteenable  out  4  constant 4'hF
- mem_clken  out  1  constant 1
- mem_readdata  in  DATA_W  RAM read data, valid one cycle after issue

## Operation
- States: IDLE, FETCH. Reset → IDLE, FIFO empty, fetch_ptr=0, inflight=0, all outputs 0 (except mem_byteenable=4'hF, mem_clken=1).
- IDLE→FETCH on start; FETCH→IDLE on halt; start in FETCH stays in FETCH. start and halt together: start wins.
- On start: fetch_ptr←start_addr, FIFO flushed, inflight flag cleared so any read issued in the start cycle or before is discarded on return.
- Issue condition (FETCH, not start, not halt): occupancy + inflight < DEPTH. Issue: mem_chipselect=1, mem_address=fetch_ptr, fetch_ptr←fetch_ptr+1 mod 2^ADDR_W (2047 wraps to 0).
- Return: cycle after a non-discarded issue, {fetch address, mem_readdata} pushed into FIFO.
- halt: no new issues; an in-flight read still lands; FIFO contents retained and drainable.
- out_valid = FIFO non-empty & ~start. Transfer when out_valid & out_ready; pop same cycle. In a start cycle no transfer occurs regardless of out_ready.
- Simultaneous push and pop: occupancy unchanged, order preserved. Push into full FIFO cannot occur (credit rule); a push would be a design error, flagged by assertion.

## Timing
- Read issued cycle k → data in FIFO at end of k+1 → out_valid in cycle k+2.
- start in cycle 0 → first issue cycle 1 → out_valid cycle 3 with out_addr=start_addr.
- With out_ready held high and DEPTH≥3: one word per cycle sustained, consecutive addresses.
- busy registered; asserts cycle after start, deasserts cycle after halt.
- reset_n assertion mid-fetch: immediate return to reset values; in-flight data never appears.

## Structure
- Package processor_fetch_pkg: state enum (IDLE, FETCH), default ADDR_W/DATA_W constants, FIFO entry struct {addr, data}.
- Sub-module processor_fetch_fifo: synchronous DEPTH-entry FIFO with flush, push, pop, occupancy count; prefetcher holds FSM, fetch pointer, inflight flag, credit logic.

## Test plan
- Reset then start with start_addr=0x010, out_ready=1 → out_valid first in cycle 3; out_addr 0x010,0x011,0x012… one per cycle, data matches RAM image.
- out_ready=0 after start → exactly DEPTH=4 reads issued, mem_chipselect then stays 0; release ready → 4 words drain in order, fetching resumes.
- start_addr=0x7FE → out_addr sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Redirect: fetching from 0x100, pulse start with 0x200 while read in flight and FIFO non-empty → no 0x1xx word after start cycle; next out_addr=0x200.
- halt with one read in flight and ready=0 → that word still enters FIFO, no further issues, busy drops next cycle; start and halt same cycle → remains FETCH from new address.
- reset_n low mid-stream with FIFO full → out_valid=0, mem_chipselect=0 immediately; after release, no stale words emitted.
